// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction-memory boot loader.
// Holds the loader FSM state encoding and the frame geometry constants.
// No logic lives here; imported by imem_loader and imem_byte_packer.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR_LO = 3'd1,
    ST_HDR_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } imem_ld_state_t;

  // Header is a 16-bit little-endian word count
  localparam int HDR_BYTES      = 2;
  // Payload bytes per instruction word
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_byte_packer.sv
// imem_byte_packer: assembles little-endian words from accepted payload bytes, keeps running XOR checksum.
// Latency: o_word_vld/o_word are combinational on the 4th accepted byte; checksum is registered.
// Backpressure: none of its own; the parent only strobes i_byte_vld on an accepted payload byte.
module imem_byte_packer
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_byte_vld,
  input  logic [7:0]            i_byte_dat,
  output logic                  o_word_vld,
  output logic [DATA_WIDTH-1:0] o_word,
  output logic [7:0]            o_csum
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [7:0]            r_csum;

  logic                  w_last_byte;
  logic [DATA_WIDTH-1:0] w_shift_nxt;

  // New bytes enter at the top and move down, so the first byte ends up in [7:0]
  always_comb begin
    w_last_byte = (r_cnt == CNT_W'(BYTES_PER_WORD - 1));
    w_shift_nxt = {i_byte_dat, r_shift[DATA_WIDTH-1:8]};
    o_word_vld  = i_byte_vld && w_last_byte;
    o_word      = w_shift_nxt;
    o_csum      = r_csum;
  end

  // Byte counter, shift register and running checksum advance only on accepted bytes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_csum  <= '0;
    end else if (i_byte_vld) begin
      r_cnt   <= w_last_byte ? '0 : r_cnt + CNT_W'(1);
      r_shift <= w_shift_nxt;
      r_csum  <= r_csum ^ i_byte_dat;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte image and writes it into instruction RAM, releasing the core on success.
// Latency: one write pulse the cycle after each word's 4th byte; release/error one cycle after the checksum byte.
// Backpressure: in_ready is registered, high only while a frame is in progress; 1 byte/cycle when streaming.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] wadr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  core_rst_n,
  output logic                  load_done,
  output logic                  err
);

  // One extra bit so the index can represent DEPTH without wrapping
  localparam int IDX_W = $clog2(DEPTH) + 1;

  imem_ld_state_t r_state;
  imem_ld_state_t w_state_nxt;

  logic [7:0]            r_n_lo;
  logic [15:0]           r_n;
  logic [IDX_W-1:0]      r_word_idx;
  logic                  r_in_ready;
  logic                  r_wen;
  logic [ADDR_WIDTH-1:0] r_wadr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_core_rst_n;
  logic                  r_load_done;
  logic                  r_err;

  logic                  w_accept;
  logic [15:0]           w_hdr_n;
  logic                  w_hdr_ok;
  logic                  w_byte_vld;
  logic                  w_last_word;
  logic                  w_word_vld;
  logic [DATA_WIDTH-1:0] w_word;
  logic [7:0]            w_csum;
  logic                  w_in_ready_nxt;
  logic                  w_done_nxt;
  logic                  w_err_nxt;

  // Handshake qualification, header bounds check and last-word detection
  always_comb begin
    w_accept    = in_valid && r_in_ready;
    w_hdr_n     = {in_data, r_n_lo};
    w_hdr_ok    = (w_hdr_n != 16'd0) && (32'(w_hdr_n) <= 32'(DEPTH));
    w_byte_vld  = w_accept && (r_state == ST_DATA);
    w_last_word = ((32'(r_word_idx) + 32'd1) == 32'(r_n));
  end

  imem_byte_packer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_byte_vld (w_byte_vld),
    .i_byte_dat (in_data),
    .o_word_vld (w_word_vld),
    .o_word     (w_word),
    .o_csum     (w_csum)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state: header, payload, checksum, then a terminal outcome
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   w_state_nxt = ST_HDR_LO;
      ST_HDR_LO: if (w_accept) w_state_nxt = ST_HDR_HI;
      ST_HDR_HI: if (w_accept) w_state_nxt = w_hdr_ok ? ST_DATA : ST_ERROR;
      ST_DATA:   if (w_word_vld && w_last_word) w_state_nxt = ST_CSUM;
      ST_CSUM:   if (w_accept) w_state_nxt = (in_data == w_csum) ? ST_DONE : ST_ERROR;
      ST_DONE:   w_state_nxt = ST_DONE;
      ST_ERROR:  w_state_nxt = ST_ERROR;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the next state so the registered versions line up with it
  always_comb begin
    w_in_ready_nxt = (w_state_nxt == ST_HDR_LO) || (w_state_nxt == ST_HDR_HI) ||
                     (w_state_nxt == ST_DATA)   || (w_state_nxt == ST_CSUM);
    w_done_nxt     = (w_state_nxt == ST_DONE);
    w_err_nxt      = (w_state_nxt == ST_ERROR);
  end

  // Header latch, word index, write port and status registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_n_lo       <= '0;
      r_n          <= '0;
      r_word_idx   <= '0;
      r_in_ready   <= 1'b0;
      r_wen        <= 1'b0;
      r_wadr       <= '0;
      r_wdata      <= '0;
      r_core_rst_n <= 1'b0;
      r_load_done  <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_in_ready   <= w_in_ready_nxt;
      r_core_rst_n <= w_done_nxt;
      r_load_done  <= w_done_nxt;
      r_err        <= w_err_nxt;
      r_wen        <= w_word_vld;
      if ((r_state == ST_HDR_LO) && w_accept) r_n_lo <= in_data;
      if ((r_state == ST_HDR_HI) && w_accept) r_n    <= w_hdr_n;
      if (w_word_vld) begin
        r_wadr     <= ADDR_WIDTH'({r_word_idx, 2'b00});
        r_wdata    <= w_word;
        r_word_idx <= r_word_idx + IDX_W'(1);
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign wen        = r_wen;
  assign wadr       = r_wadr;
  assign wdata      = r_wdata;
  assign core_rst_n = r_core_rst_n;
  assign load_done  = r_load_done;
  assign err        = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader with a write scoreboard.
// Expected RAM writes are queued as bytes are driven and popped when wen pulses.
// Status outputs are checked after each frame outcome.
module tb_imem_loader;

  localparam int LIMIT = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        wen;
  logic [31:0] wadr;
  logic [31:0] wdata;
  logic        core_rst_n;
  logic        load_done;
  logic        err;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int n_writes = 0;
  int first_wen_cyc = -1;
  int last_wen_cyc  = -1;

  logic [63:0] sb[$];
  logic [31:0] img[$];

  always #5 clk = ~clk;

  imem_loader #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH      (256)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .wen        (wen),
    .wadr       (wadr),
    .wdata      (wdata),
    .core_rst_n (core_rst_n),
    .load_done  (load_done),
    .err        (err)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Write monitor: every wen pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && wen === 1'b1) begin
      logic [63:0] e;
      n_writes++;
      if (first_wen_cyc < 0) first_wen_cyc = cyc;
      last_wen_cyc = cyc;
      check("wen_before_release", 32'(core_rst_n), 32'd0);
      if (sb.size() == 0) begin
        check("wen_unexpected", 32'(wen), 32'd0);
      end else begin
        e = sb.pop_front();
        check("wadr", wadr, e[63:32]);
        check("wdata", wdata, e[31:0]);
      end
    end
  end

  task automatic check_status(input string tag, input logic rdy, input logic crst,
                              input logic done, input logic e);
    check({tag, "_in_ready"},   32'(in_ready),   32'(rdy));
    check({tag, "_core_rst_n"}, 32'(core_rst_n), 32'(crst));
    check({tag, "_load_done"},  32'(load_done),  32'(done));
    check({tag, "_err"},        32'(err),        32'(e));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_wen",   32'(wen), 32'd0);
    check("rst_wadr",  wadr,     32'd0);
    check("rst_wdata", wdata,    32'd0);
    check_status("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    sb.delete();
    n_writes      = 0;
    first_wen_cyc = -1;
    last_wen_cyc  = -1;
    rst_n = 1'b1;
  endtask

  // Called and returns at a falling edge; the byte is accepted at the rising edge in between
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (in_ready !== 1'b1 && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    if (t >= LIMIT) check("byte_accept_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Sends header, img[] payload and checksum; queues expected writes as each 4th byte goes out
  task automatic send_frame(input int gap_max, input logic [7:0] csum_flip);
    logic [15:0] nn;
    logic [31:0] w;
    logic [7:0]  b;
    logic [7:0]  cs;
    nn = 16'(img.size());
    cs = 8'h00;
    send_byte(nn[7:0],  $urandom_range(0, gap_max));
    send_byte(nn[15:8], $urandom_range(0, gap_max));
    for (int i = 0; i < img.size(); i++) begin
      w = img[i];
      for (int k = 0; k < 4; k++) begin
        b  = w[8*k +: 8];
        cs = cs ^ b;
        if (k == 3) sb.push_back({32'(i * 4), w});
        send_byte(b, $urandom_range(0, gap_max));
      end
    end
    send_byte(cs ^ csum_flip, $urandom_range(0, gap_max));
  endtask

  task automatic drain(input string tag, input int exp_writes);
    repeat (3) @(negedge clk);
    check({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
    check({tag, "_n_writes"},   32'(n_writes),  32'(exp_writes));
  endtask

  initial begin
    // Reset state and first ready timing
    do_reset();
    check("ready_low_first_cycle", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("ready_rises_after_idle", 32'(in_ready), 32'd1);

    // Single word: 01 00 13 00 00 00 13
    img.delete();
    img.push_back(32'h0000_0013);
    send_frame(0, 8'h00);
    check_status("single", 1'b0, 1'b1, 1'b1, 1'b0);
    drain("single", 1);
    check("single_wadr_hold",  wadr,  32'h0000_0000);
    check("single_wdata_hold", wdata, 32'h0000_0013);
    check_status("single_sticky", 1'b0, 1'b1, 1'b1, 1'b0);

    // Three words with random valid gaps
    do_reset();
    img.delete();
    img.push_back(32'h0000_0013);
    img.push_back(32'h0010_0093);
    img.push_back(32'h0020_8113);
    send_frame(3, 8'h00);
    check_status("three", 1'b0, 1'b1, 1'b1, 1'b0);
    drain("three", 3);

    // Bad checksum: word still written, error raised
    do_reset();
    img.delete();
    img.push_back(32'h0000_0013);
    send_frame(0, 8'h01);
    check_status("badcsum", 1'b0, 1'b0, 1'b0, 1'b1);
    drain("badcsum", 1);

    // Illegal header N=0
    do_reset();
    send_byte(8'h00, 0);
    check("n0_err_after_lo", 32'(err), 32'd0);
    send_byte(8'h00, 0);
    check_status("n0", 1'b0, 1'b0, 1'b0, 1'b1);
    drain("n0", 0);

    // Illegal header N=257
    do_reset();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    check_status("n257", 1'b0, 1'b0, 1'b0, 1'b1);
    drain("n257", 0);

    // Full image back to back
    do_reset();
    img.delete();
    for (int i = 0; i < 256; i++) img.push_back($urandom());
    send_frame(0, 8'h00);
    check_status("full", 1'b0, 1'b1, 1'b1, 1'b0);
    drain("full", 256);
    check("full_last_wadr", wadr, 32'h0000_03FC);
    check("full_write_span", 32'(last_wen_cyc - first_wen_cyc), 32'd1020);

    // Reset after 6 payload bytes of a 2-word frame
    do_reset();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    sb.push_back({32'h0, 32'hDDCC_BBAA});
    send_byte(8'hDD, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    drain("midrst_pre", 1);
    do_reset();
    img.delete();
    img.push_back(32'h0000_0013);
    send_frame(1, 8'h00);
    check_status("midrst", 1'b0, 1'b1, 1'b1, 1'b0);
    drain("midrst", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory writer for the pipelined RV32 core. It receives a byte stream (from a UART/debug receiver) over a valid/ready handshake and assembles little-endian 32-bit words. It writes them through the instruction RAM's write port (`wen`/`wadr`/`wdata`) and holds the core in reset until a complete, checksum-verified image is loaded. It is the writer for the otherwise read-only instruction RAM that the fetch stage reads.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: width of `wadr`; matches the PC/instruction-RAM address width.
- `DATA_WIDTH`, default 32: instruction word width; fixed at 32.
- `DEPTH`, default 256: capacity of the instruction RAM in words; the maximum image length.

Ports:
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset; synchronous, active-low.
- `in_valid`, input, 1: a byte is offered on `in_data`.
- `in_data`, input, 8: byte from the loader link.
- `in_ready`, output, 1: the loader accepts a byte this cycle.
- `wen`, output, 1: instruction RAM write enable, one-cycle pulse per word.
- `wadr`, output, ADDR_WIDTH: byte address of the word, `{word_idx, 2'b00}`; same addressing as the PC.
- `wdata`, output, 32: assembled instruction word.
- `core_rst_n`, output, 1: active-low reset to the pipeline; 0 until the load succeeds.
- `load_done`, output, 1: the image was loaded and verified; sticky.
- `err`, output, 1: framing or checksum error; sticky until `rst_n`.

## Operation
- A byte is accepted when `in_valid && in_ready` is high at a rising clock edge.
- Frame layout, in order:
  - `N` low byte, then `N` high byte (16-bit word count).
  - `4*N` payload bytes, little-endian: the first byte of each word goes to `wdata[7:0]`.
  - One checksum byte, equal to the XOR of all payload bytes.
- FSM states: IDLE, HDR_LO, HDR_HI, DATA, CSUM, DONE, ERROR.
  - IDLE → HDR_LO unconditionally on the first cycle after reset.
  - HDR_LO → HDR_HI when a byte is accepted; the byte is latched as `N[7:0]`.
  - HDR_HI → DATA when a byte is accepted and `1 <= N <= DEPTH`; otherwise HDR_HI → ERROR.
  - DATA: a 2-bit byte counter shifts bytes into the word register. Each accepted byte is XORed into the running checksum.
    - On the 4th byte of a word, the word is written and `word_idx` increments.
    - When the 4th byte of word `N-1` is accepted, DATA → CSUM.
  - CSUM → DONE if the accepted byte equals the running checksum; otherwise CSUM → ERROR.
  - DONE and ERROR are terminal; only `rst_n` leaves them.
- `in_ready` is 1 only in HDR_LO, HDR_HI, DATA and CSUM; it is 0 in IDLE, DONE and ERROR.
- `word_idx` is `$clog2(DEPTH)+1` bits wide. `wadr` is zero-extended to ADDR_WIDTH. `word_idx` never wraps, because `N <= DEPTH` is enforced at the header.
- Bytes offered in DONE or ERROR are not accepted; upstream sees `in_ready=0`.

## Timing
- Reset values: `in_ready=0`, `wen=0`, `wadr=0`, `wdata=0`, `core_rst_n=0`, `load_done=0`, `err=0`, state IDLE, all counters and checksum 0.
- `in_ready` is a registered output. It first rises 1 cycle after `rst_n` deasserts, once IDLE → HDR_LO.
- Write latency:
  - `wen`, `wadr` and `wdata` are registered.
  - `wen` is high for exactly 1 cycle, the cycle after the 4th byte of a word is accepted.
  - `wadr` and `wdata` hold their value until the next write.
- Back-to-back streaming (`in_valid` held high) sustains 1 byte per cycle, so one write every 4 cycles. There are no bubbles between header, payload and checksum.
- Release on success:
  - `core_rst_n` and `load_done` go to 1 the cycle after a matching checksum byte is accepted.
  - The final `wen` occurs at least 1 cycle before `core_rst_n` rises.
- Error: `err` goes to 1 the cycle after the offending byte is accepted. `core_rst_n` stays 0.
- Reset mid-operation: when `rst_n=0` is sampled, all state returns to reset values at that edge. A partial word is discarded, not written. The next frame restarts at the header with `wadr=0`.
- `in_valid` gaps have no effect on the partial word or the checksum. There is no timeout.

## Structure
- Package `imem_loader_pkg` holds:
  - the state enum, `imem_ld_state_t`;
  - `HDR_BYTES=2`;
  - `BYTES_PER_WORD=4`.
- One sub-module is natural: `imem_byte_packer`. It contains the byte counter, the shift register for little-endian word assembly and the running XOR checksum. It outputs a `word_valid` strobe plus `word`.
- `imem_loader` itself owns the FSM, header latch, `word_idx`, write-port registers and `core_rst_n`.
- At top level, `imem_loader` drives the instruction RAM's `wen`/`wadr`/`wdata`. Its `core_rst_n` gates the pipeline reset, ANDed with `rst_n`.

## Test plan
- **Single word:** bytes `01 00 13 00 00 00 13` → one `wen` pulse with `wadr=0x0`, `wdata=0x00000013`; then `core_rst_n=1`, `load_done=1`, `err=0`, `in_ready=0`.
- **Three words with random `in_valid` gaps:** payload `0x00000013`, `0x00100093`, `0x00208113` → writes at `wadr` 0x0, 0x4, 0x8 with those values, in order. Checksum = XOR of the 12 payload bytes → success.
- **Bad checksum:** same as the single-word case but the checksum byte is `0x12` → `err=1` one cycle after the byte, `core_rst_n=0`, `load_done=0`, `in_ready=0`. The word at address 0 was still written.
- **Illegal header:** `N=0` (`00 00`), and separately `N=257` (`01 01`) → `err=1` after the high byte; no `wen` at any point.
- **Full image:** `N=256`, streamed back-to-back → 256 writes, one every 4 cycles; last write at `wadr=0x3FC`; `core_rst_n` rises after the checksum.
- **Reset mid-payload:** assert `rst_n=0` after 6 payload bytes, then send a fresh 1-word frame → no write of the partial word; the new word is written at `wadr=0x0` and the load completes.
